pixel_reader: RTL and testbench
===============================

PIXEL_READER -- requirements
Module: pixel_reader

Interface
REQ-001 Parameter IMG_DIM, default 32, pixels per row and rows per frame; power of two, 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to stream one frame; sampled only in IDLE.
REQ-005 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-006 done  output  1  one-cycle pulse, the cycle after the last pixel handshake.
REQ-007 read_pixel_addr  output  16  pixel-memory read address: [15:10]=0, [9:5]=row, [4:0]=col.
REQ-008 read_pixel_signal  output  1  pixel-memory read enable.
REQ-009 read_pixel_data  input  48  pixel word: [15:0] R, [31:16] G, [47:32] B; valid one cycle after the address, and only while read_pixel_signal is high.
REQ-010 pix_valid  output  1  output pixel available.
REQ-011 pix_ready  input  1  consumer accepts; a transfer occurs when pix_valid and pix_ready are both high.
REQ-012 pix_data  output  48  pixel word, same channel layout as read_pixel_data.
REQ-013 pix_row, pix_col  output  5 each  raster coordinates of pix_data.
REQ-014 pix_last  output  1  high with the final pixel (row=col=IMG_DIM-1).

Function
REQ-015 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after the last read is issued; DRAIN->IDLE on the last pixel transfer; done pulses on that IDLE entry.
REQ-016 Reads are issued in raster order: col increments first, then wraps to 0 and row increments; no address beyond IMG_DIM-1 in either coordinate.
REQ-017 Output path is a 2-entry FIFO carrying {data,row,col,last}; a read is issued only when FIFO occupancy plus in-flight reads < 2.
REQ-018 Read latency is fixed at 1 cycle: data is captured into the FIFO in the cycle after issue.
REQ-019 read_pixel_signal is high in every issue cycle and every capture cycle; in a capture-only cycle read_pixel_addr holds its previous value.
REQ-020 pix_valid is high whenever the FIFO is non-empty; pix_data/row/col/last are stable while pix_valid=1 and pix_ready=0.
REQ-021 With pix_ready held high, throughput is one pixel per cycle; first pix_valid is 2 cycles after start.
REQ-022 Simultaneous FIFO push and pop with FIFO full is legal and keeps occupancy at 2; no pixel is dropped or duplicated.
REQ-023 start while busy=1 is ignored; no restart or address change occurs.
REQ-024 Exactly IMG_DIM*IMG_DIM transfers occur per frame; done is never asserted without pix_last having been transferred.

Reset
REQ-025 rst=0 at a clock edge returns the FSM to IDLE, clears the FIFO, counters, and in-flight flag, including mid-frame.
REQ-026 Reset values: busy=0, done=0, pix_valid=0, pix_last=0, read_pixel_signal=0, read_pixel_addr=0, pix_data=0, pix_row=0, pix_col=0.
REQ-027 The first start accepted after reset streams a complete frame from (0,0); no residue from the aborted frame appears.

Structure
REQ-028 Shared package holds the FSM state enum, the 48-bit pixel-word typedef, channel bit-slice constants, and the address-field bit positions shared with the pixel-memory writer.
REQ-029 The 2-entry FIFO is a separate sub-module, pixel_skid_fifo, parameterised by payload width.

Verification
REQ-030 Memory model preloaded with R=addr, G=addr+1000, B=addr+2000; start, pix_ready=1 -> 1024 transfers in 1024 consecutive cycles, pixel n = {n+2000,n+1000,n}, done 1 cycle after the last transfer.
REQ-031 pix_ready toggled by random 50% pattern -> same 1024-pixel sequence, no gaps or repeats, outputs stable during stalls.
REQ-032 pix_ready=0 for 20 cycles after start -> at most 2 reads issued, pix_data holds pixel 0, stream resumes in order on release.
REQ-033 rst=0 at pixel 500 then start -> busy=0 and pix_valid=0 the cycle after reset, new frame begins at (0,0).
REQ-034 Second start pulse at pixel 10 -> ignored, exactly 1024 transfers, single done pulse.
REQ-035 Every cycle a read address is presented or captured, read_pixel_signal=1, and read_pixel_addr[15:10]=0 throughout.

Source files
------------

// File: rtl/pixel_reader_pkg.sv
// Types and constants shared by the pixel reader, its output FIFO and the
// pixel-memory writer (word layout and address field positions).
package pixel_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [47:0] pixel_t;

  localparam int R_LSB = 0;
  localparam int R_MSB = 15;
  localparam int G_LSB = 16;
  localparam int G_MSB = 31;
  localparam int B_LSB = 32;
  localparam int B_MSB = 47;

  localparam int ADDR_W       = 16;
  localparam int COORD_W      = 5;
  localparam int ADDR_COL_LSB = 0;
  localparam int ADDR_ROW_LSB = 5;

  typedef struct packed {
    pixel_t               data;
    logic [COORD_W-1:0]   row;
    logic [COORD_W-1:0]   col;
    logic                 last;
  } pix_entry_t;

  // Upper address bits stay zero; only row and col fields are populated.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] row,
                                                   input logic [COORD_W-1:0] col);
    logic [ADDR_W-1:0] addr;
    addr = '0;
    addr[ADDR_ROW_LSB +: COORD_W] = row;
    addr[ADDR_COL_LSB +: COORD_W] = col;
    return addr;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO between the pixel memory and the consumer; tolerates a push
// and a pop in the same cycle even when full.
module pixel_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_data = mem[rd_ptr];
  assign not_empty = (count != 2'd0);

endmodule

// File: rtl/pixel_reader.sv
// Streams one IMG_DIM x IMG_DIM frame from pixel memory in raster order onto a
// valid/ready interface, with a 1-cycle memory latency absorbed by a 2-entry FIFO.
module pixel_reader
  import pixel_reader_pkg::*;
#(
  parameter int IMG_DIM = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] read_pixel_addr,
  output logic        read_pixel_signal,
  input  logic [47:0] read_pixel_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [47:0] pix_data,
  output logic [4:0]  pix_row,
  output logic [4:0]  pix_col,
  output logic        pix_last
);

  localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(IMG_DIM - 1);

  state_t             state;
  state_t             state_nxt;
  logic [COORD_W-1:0] row_cnt;
  logic [COORD_W-1:0] col_cnt;
  logic [COORD_W-1:0] fl_row;
  logic [COORD_W-1:0] fl_col;
  logic               fl_last;
  logic               in_flight;
  logic [ADDR_W-1:0]  last_addr;
  logic               done_q;
  logic               issue;
  logic               issue_last;
  logic               fifo_pop;
  logic               fifo_valid;
  logic [1:0]         fifo_count;
  pix_entry_t         push_entry;
  pix_entry_t         head_entry;

  assign fifo_pop   = fifo_valid && pix_ready;
  assign issue_last = (row_cnt == MAX_COORD) && (col_cnt == MAX_COORD);
  // Counting this cycle's pop lets a read issue every cycle while the consumer keeps up.
  assign issue      = (state == RUN) &&
                      (({1'b0, fifo_count} + {2'b0, in_flight} - {2'b0, fifo_pop}) < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue && issue_last) state_nxt = DRAIN;
      DRAIN:   if (fifo_pop && head_entry.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      fl_row    <= '0;
      fl_col    <= '0;
      fl_last   <= 1'b0;
      in_flight <= 1'b0;
      last_addr <= '0;
      done_q    <= 1'b0;
    end else begin
      in_flight <= issue;
      done_q    <= (state == DRAIN) && (state_nxt == IDLE);
      if (issue) begin
        fl_row    <= row_cnt;
        fl_col    <= col_cnt;
        fl_last   <= issue_last;
        last_addr <= pixel_addr(row_cnt, col_cnt);
        if (col_cnt == MAX_COORD) begin
          col_cnt <= '0;
          row_cnt <= issue_last ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy              = (state != IDLE);
    done              = done_q;
    read_pixel_signal = issue || in_flight;
    read_pixel_addr   = issue ? pixel_addr(row_cnt, col_cnt) : last_addr;
  end

  assign push_entry = '{data: read_pixel_data, row: fl_row, col: fl_col, last: fl_last};

  pixel_skid_fifo #(
    .WIDTH($bits(pix_entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_flight),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .head_data(head_entry),
    .not_empty(fifo_valid),
    .count    (fifo_count)
  );

  assign pix_valid = fifo_valid;
  assign pix_data  = head_entry.data;
  assign pix_row   = head_entry.row;
  assign pix_col   = head_entry.col;
  assign pix_last  = fifo_valid && head_entry.last;

endmodule

// File: tb/tb_pixel_reader.sv
// Directed bench for pixel_reader: memory model returns R=addr, G=addr+1000,
// B=addr+2000; a scoreboard expects pixels 0..1023 strictly in raster order.
module tb_pixel_reader;
  import pixel_reader_pkg::*;

  localparam int DIM  = 32;
  localparam int NPIX = DIM * DIM;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] read_pixel_addr;
  logic        read_pixel_signal;
  logic [47:0] read_pixel_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [47:0] pix_data;
  logic [4:0]  pix_row;
  logic [4:0]  pix_col;
  logic        pix_last;

  int check_cnt = 0;
  int err_cnt = 0;
  int exp_n = 0;
  int done_cnt = 0;
  int cyc = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  bit mon_en = 1'b0;

  pixel_reader #(.IMG_DIM(DIM)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .read_pixel_addr  (read_pixel_addr),
    .read_pixel_signal(read_pixel_signal),
    .read_pixel_data  (read_pixel_data),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_data         (pix_data),
    .pix_row          (pix_row),
    .pix_col          (pix_col),
    .pix_last         (pix_last)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] exp_word(input int n);
    logic [47:0] w;
    w = '0;
    w[R_MSB:R_LSB] = 16'(n);
    w[G_MSB:G_LSB] = 16'(n + 1000);
    w[B_MSB:B_LSB] = 16'(n + 2000);
    return w;
  endfunction

  // Data appears one cycle after the address; reads without enable return junk.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_pixel_signal) read_pixel_data <= exp_word(int'(read_pixel_addr[9:0]));
    else                   read_pixel_data <= 48'hBAD0_BAD0_BAD0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Whenever a pixel is presented it must be the next one in raster order.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("addr_hi_zero", 64'(read_pixel_addr[15:10]), 64'd0);
      if (pix_valid) begin
        if (exp_n >= NPIX) begin
          checkOutput("overrun", 64'(exp_n), 64'(NPIX - 1));
        end else begin
          checkOutput("pix_data", pix_data, exp_word(exp_n));
          checkOutput("pix_row", 64'(pix_row), 64'(exp_n / DIM));
          checkOutput("pix_col", 64'(pix_col), 64'(exp_n % DIM));
          checkOutput("pix_last", 64'(pix_last), 64'(exp_n == NPIX - 1));
          if (pix_ready) begin
            if (exp_n == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            exp_n++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        checkOutput("done_after_last", 64'(exp_n), 64'(NPIX));
        checkOutput("done_latency", 64'(cyc - last_xfer_cyc), 64'd1);
      end
    end
  end

  // mode 0: ready high, 1: random ready, 2: 20-cycle initial stall, 3: second start at pixel 10
  task automatic applyStimulus(input int mode);
    bit pulsed;
    pulsed   = 1'b0;
    exp_n    = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    pix_ready = (mode == 0 || mode == 3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    if (mode == 0) begin
      checkOutput("valid_c1", 64'(pix_valid), 64'd0);
      @(negedge clk);
      checkOutput("valid_c2", 64'(pix_valid), 64'd0);
      @(negedge clk);
      checkOutput("valid_c3", 64'(pix_valid), 64'd1);
    end
    if (mode == 2) begin
      repeat (19) @(negedge clk);
      checkOutput("stall_rd_sig", 64'(read_pixel_signal), 64'd0);
      checkOutput("stall_rd_addr", 64'(read_pixel_addr), 64'd1);
      checkOutput("stall_data", pix_data, exp_word(0));
      checkOutput("stall_no_xfer", 64'(exp_n), 64'd0);
    end
    for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      case (mode)
        1: pix_ready = 1'($urandom_range(0, 1));
        3: begin
          pix_ready = 1'b1;
          start     = (exp_n == 10) && !pulsed;
          if (start) pulsed = 1'b1;
        end
        default: pix_ready = 1'b1;
      endcase
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("xfer_count", 64'(exp_n), 64'(NPIX));
    checkOutput("done_count", 64'(done_cnt), 64'd1);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_valid", 64'(pix_valid), 64'd0);
    if (mode == 0) checkOutput("consecutive", 64'(last_xfer_cyc - first_xfer_cyc), 64'(NPIX - 1));
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_valid", 64'(pix_valid), 64'd0);
    checkOutput("rst_last", 64'(pix_last), 64'd0);
    checkOutput("rst_rd_sig", 64'(read_pixel_signal), 64'd0);
    checkOutput("rst_rd_addr", 64'(read_pixel_addr), 64'd0);
    checkOutput("rst_data", pix_data, 64'd0);
    checkOutput("rst_row", 64'(pix_row), 64'd0);
    checkOutput("rst_col", 64'(pix_col), 64'd0);
    @(posedge clk); #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    $display("[TB] full-rate frame");
    applyStimulus(0);
    $display("[TB] random backpressure frame");
    applyStimulus(1);
    $display("[TB] initial stall frame");
    applyStimulus(2);
    $display("[TB] ignored second start frame");
    applyStimulus(3);

    $display("[TB] reset mid-frame");
    exp_n    = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2000 && exp_n < 500; i++) @(posedge clk);
    #1;
    checkOutput("pre_reset_progress", 64'(exp_n), 64'd500);
    mon_en = 1'b0;
    rst    = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_valid", 64'(pix_valid), 64'd0);
    checkOutput("midrst_rd_sig", 64'(read_pixel_signal), 64'd0);
    mon_en = 1'b1;
    applyStimulus(0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
